// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Word width, FSM state encoding and port selectors.
package unified_mem_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    I_WAIT = 2'b01,
    D_WAIT = 2'b10
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Core-side and memory-side bus of the unified memory arbiter.
// slave: arbiter view; master: core + memory view.
interface unified_mem_arbiter_if;
  import unified_mem_arbiter_pkg::*;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;
  logic                 d_read;
  logic                 d_write;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;
  logic                 m_read;
  logic                 m_write;
  logic [WORD_SIZE-1:0] m_addr;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 stall_if;
  logic                 stall_mem;
  logic                 protocol_err;

  modport slave (
    input  i_req, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  m_rdata,
    output i_data, i_ready,
    output d_rdata, d_ready,
    output m_read, m_write, m_addr, m_wdata,
    output stall_if, stall_mem, protocol_err
  );

  modport master (
    output i_req, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output m_rdata,
    input  i_data, i_ready,
    input  d_rdata, d_ready,
    input  m_read, m_write, m_addr, m_wdata,
    input  stall_if, stall_mem, protocol_err
  );

endinterface

// File: rtl/unified_mem_arbiter_counter.sv
// Memory latency down-counter; saturates at zero.
// done flags the last wait cycle of an access.
module mem_latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // load wins over decrement; stop at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory shared by fetch and data ports.
// Data has priority; a ready cycle hands the slot to the other port.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  unified_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

  state_t state_q, state_d;

  logic                 wr_q;
  logic                 i_ready_q, d_ready_q;
  logic                 m_read_q, m_write_q;
  logic                 err_q;
  logic [WORD_SIZE-1:0] i_data_q, d_rdata_q;
  logic [WORD_SIZE-1:0] m_addr_q, m_wdata_q;

  logic d_elig, i_elig;
  logic grant_d, grant_i, grant;
  logic sel;
  logic cnt_done, finish;

  // a port whose ready is high this cycle has its request consumed
  assign d_elig  = (bus.d_read | bus.d_write) & ~d_ready_q;
  assign i_elig  = bus.i_req & ~i_ready_q;
  assign grant_d = (state_q == IDLE) & d_elig;
  assign grant_i = (state_q == IDLE) & ~d_elig & i_elig;
  assign grant   = grant_d | grant_i;
  assign sel     = grant_d ? PORT_D : PORT_I;
  assign finish  = (state_q != IDLE) & cnt_done;

  mem_latency_counter #(
    .W (CW)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (grant),
    .load_val (LAT),
    .dec      (state_q != IDLE),
    .done     (cnt_done)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: grant from IDLE, return when latency expires
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_d: state_d = D_WAIT;
          grant_i: state_d = I_WAIT;
          default: state_d = IDLE;
        endcase
      end
      I_WAIT, D_WAIT: begin
        if (cnt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // command, capture and ready registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      m_read_q  <= grant & ~(grant_d & bus.d_write);
      m_write_q <= grant_d & bus.d_write;
      i_ready_q <= finish & (state_q == I_WAIT);
      d_ready_q <= finish & (state_q == D_WAIT);
      if (grant) begin
        m_addr_q <= (sel == PORT_D) ? bus.d_addr : bus.i_addr;
      end
      if (grant_d) begin
        m_wdata_q <= bus.d_wdata;
        wr_q      <= bus.d_write;
        if (bus.d_read & bus.d_write) err_q <= 1'b1;
      end
      if (finish && state_q == I_WAIT) begin
        i_data_q <= bus.m_rdata;
      end
      if (finish && state_q == D_WAIT && !wr_q) begin
        d_rdata_q <= bus.m_rdata;
      end
    end
  end

  assign bus.i_data       = i_data_q;
  assign bus.i_ready      = i_ready_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_ready      = d_ready_q;
  assign bus.m_read       = m_read_q;
  assign bus.m_write      = m_write_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_wdata      = m_wdata_q;
  assign bus.protocol_err = err_q;
  assign bus.stall_if     = bus.i_req & ~i_ready_q;
  assign bus.stall_mem    = (bus.d_read | bus.d_write) & ~d_ready_q;

endmodule
